// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, ALU op codes and the
// decoder control bundle layout consumed by the ID/EX register.
package cpu_pkg;

  localparam int unsigned CTRL_W = 14;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGE  = 6'b000001;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SLTI   = 3'b001;
  localparam logic [2:0] ALU_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_BRANCH = 3'b100;

  localparam int unsigned CTRL_REG_WRITE  = 13;
  localparam int unsigned CTRL_ALU_OP_HI  = 12;
  localparam int unsigned CTRL_ALU_OP_LO  = 10;
  localparam int unsigned CTRL_ALU_SRC    = 9;
  localparam int unsigned CTRL_REG_DST    = 8;
  localparam int unsigned CTRL_BEQ        = 7;
  localparam int unsigned CTRL_BNE        = 6;
  localparam int unsigned CTRL_BGE        = 5;
  localparam int unsigned CTRL_BGT        = 4;
  localparam int unsigned CTRL_MEM_READ   = 3;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 1;
  localparam int unsigned CTRL_PAD0       = 0;

  // Field order matches the bit positions above (MSB first).
  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       beq;
    logic       bne;
    logic       bge;
    logic       bgt;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pad0;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination (rt)
// is read by the instruction in ID. Register 0 never hazards.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              lu
);

  always_comb begin
    lu = ex_mem_read && ex_valid && (ex_rt != '0) &&
         ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with bubble insertion on flush and load-use hazards.
// Load-use detection is built only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [5:0]        id_funct_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [5:0]        ex_funct_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_valid_o,
  output logic              pc_write_o,
  output logic              ifid_write_o
);

  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] pc4_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [5:0]        funct_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic              valid_q;
  logic              lu;

`ifdef ID_EX_HAZARD_DETECT_EN
  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_valid    (valid_q),
    .ex_rt       (rt_q),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .lu          (lu)
  );
`else
  assign lu = 1'b0;
`endif

  // Bubbles clear every field so stale addresses never reach forwarding.
  always_ff @(posedge clk_i) begin
    if (rst_i || (!stall_i && (flush_i || lu))) begin
      ctrl_q    <= '0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      funct_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
    end else if (!stall_i) begin
      ctrl_q    <= ctrl_t'(id_ctrl_i);
      pc4_q     <= id_pc4_i;
      rs_data_q <= id_rs_data_i;
      rt_data_q <= id_rt_data_i;
      imm_q     <= id_imm_i;
      funct_q   <= id_funct_i;
      rs_q      <= id_rs_i;
      rt_q      <= id_rt_i;
      rd_q      <= id_rd_i;
      valid_q   <= 1'b1;
    end
  end

  // A flush discards the ID instruction, so it must never freeze the front end.
  always_comb begin
    pc_write_o   = !stall_i && (flush_i || !lu);
    ifid_write_o = !stall_i && (flush_i || !lu);
  end

  assign ex_ctrl_o    = CTRL_W'(ctrl_q);
  assign ex_pc4_o     = pc4_q;
  assign ex_rs_data_o = rs_data_q;
  assign ex_rt_data_o = rt_data_q;
  assign ex_imm_o     = imm_q;
  assign ex_funct_o   = funct_q;
  assign ex_rs_o      = rs_q;
  assign ex_rt_o      = rt_q;
  assign ex_rd_o      = rd_q;
  assign ex_valid_o   = valid_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe; expectations follow ID_EX_HAZARD_DETECT_EN.
module tb_id_ex_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i, flush_i, stall_i;
  logic [13:0]       id_ctrl_i;
  logic [DATA_W-1:0] id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [5:0]        id_funct_i;
  logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i;
  logic [13:0]       ex_ctrl_o;
  logic [DATA_W-1:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [5:0]        ex_funct_o;
  logic [REG_AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
  logic              ex_valid_o, pc_write_o, ifid_write_o;

  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .id_ctrl_i(id_ctrl_i), .id_pc4_i(id_pc4_i), .id_rs_data_i(id_rs_data_i),
    .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i), .id_funct_i(id_funct_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_ctrl_o(ex_ctrl_o), .ex_pc4_o(ex_pc4_o), .ex_rs_data_o(ex_rs_data_o),
    .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o), .ex_funct_o(ex_funct_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_valid_o(ex_valid_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o)
  );

  typedef struct packed {
    logic [13:0]       ctrl;
    logic [DATA_W-1:0] pc4, rs_data, rt_data, imm;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              valid;
  } ex_t;

  localparam logic [13:0] C_ADDI = 14'h2200;
  localparam logic [13:0] C_LW   = 14'h220A;
  localparam logic [13:0] C_ADD  = 14'h2900;

  ex_t model = '0;
  ex_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [13:0] c, input logic [31:0] pc4, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_ctrl_i = c; id_pc4_i = pc4; id_rs_data_i = rsd; id_rt_data_i = rtd;
    id_imm_i = imm; id_funct_i = fn; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
  endtask

  // One clock: check the upstream enables, push the expected EX state, then compare it.
  task automatic cycle(input bit chk_pcw);
    ex_t nxt, got;
    logic lu, pcw;
    #1;
    lu  = HD && model.ctrl[3] && model.valid && (model.rt != '0) &&
          ((model.rt == id_rs_i) || (model.rt == id_rt_i));
    pcw = !stall_i && (flush_i || !lu);
    if (chk_pcw) begin
      chk("pc_write", 64'(pc_write_o), 64'(pcw));
      chk("ifid_write", 64'(ifid_write_o), 64'(pcw));
    end
    if (rst_i)                nxt = '0;
    else if (stall_i)         nxt = model;
    else if (flush_i || lu)   nxt = '0;
    else nxt = '{ctrl: id_ctrl_i, pc4: id_pc4_i, rs_data: id_rs_data_i, rt_data: id_rt_data_i,
                 imm: id_imm_i, funct: id_funct_i, rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                 valid: 1'b1};
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("ex_ctrl", 64'(ex_ctrl_o), 64'(got.ctrl));
    chk("ex_pc4", 64'(ex_pc4_o), 64'(got.pc4));
    chk("ex_rs_data", 64'(ex_rs_data_o), 64'(got.rs_data));
    chk("ex_rt_data", 64'(ex_rt_data_o), 64'(got.rt_data));
    chk("ex_imm", 64'(ex_imm_o), 64'(got.imm));
    chk("ex_funct", 64'(ex_funct_o), 64'(got.funct));
    chk("ex_rs", 64'(ex_rs_o), 64'(got.rs));
    chk("ex_rt", 64'(ex_rt_o), 64'(got.rt));
    chk("ex_rd", 64'(ex_rd_o), 64'(got.rd));
    chk("ex_valid", 64'(ex_valid_o), 64'(got.valid));
    model = got;
  endtask

  initial begin
    // T1 reset with all-ones inputs
    rst_i = 1'b1; flush_i = 1'b1; stall_i = 1'b1;
    set_id('1, '1, '1, '1, '1, '1, '1, '1, '1);
    cycle(1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    cycle(1'b1);
    chk("t1_valid", 64'(ex_valid_o), 64'd0);
    rst_i = 1'b0;

    // T2 addi capture
    set_id(C_ADDI, 32'h104, 32'h5, 32'h0, 32'h7, 6'h0, 5'd1, 5'd9, 5'd0);
    cycle(1'b1);
    chk("t2_ctrl", 64'(ex_ctrl_o), 64'(C_ADDI));
    chk("t2_imm", 64'(ex_imm_o), 64'h7);

    // T3 load-use: lw rt=8 then add rs=8, held for the stall then captured
    set_id(C_LW, 32'h108, 32'h40, 32'h0, 32'h10, 6'h0, 5'd2, 5'd8, 5'd0);
    cycle(1'b1);
    set_id(C_ADD, 32'h10C, 32'h11, 32'h22, 32'h0, 6'h20, 5'd8, 5'd2, 5'd3);
    cycle(1'b1);
    cycle(1'b1);
    chk("t3_ctrl", 64'(ex_ctrl_o), 64'(C_ADD));

    // T4 r0 and unrelated registers: never a hazard
    set_id(C_LW, 32'h110, 32'h0, 32'h0, 32'h4, 6'h0, 5'd0, 5'd0, 5'd0);
    cycle(1'b1);
    set_id(C_ADD, 32'h114, 32'h1, 32'h2, 32'h0, 6'h20, 5'd0, 5'd0, 5'd5);
    cycle(1'b1);
    set_id(C_LW, 32'h118, 32'h80, 32'h0, 32'h8, 6'h0, 5'd2, 5'd8, 5'd0);
    cycle(1'b1);
    set_id(C_ADD, 32'h11C, 32'h3, 32'h4, 32'h0, 6'h20, 5'd3, 5'd4, 5'd6);
    cycle(1'b1);

    // T5 flush together with load-use conditions
    set_id(C_LW, 32'h120, 32'h80, 32'h0, 32'h8, 6'h0, 5'd2, 5'd8, 5'd0);
    cycle(1'b1);
    set_id(C_ADD, 32'h124, 32'h3, 32'h4, 32'h0, 6'h20, 5'd8, 5'd4, 5'd6);
    flush_i = 1'b1;
    cycle(1'b1);
    flush_i = 1'b0;
    chk("t5_valid", 64'(ex_valid_o), 64'd0);

    // T6 external stall for 3 cycles while ID changes
    set_id(C_ADDI, 32'h200, 32'hA, 32'hB, 32'hC, 6'h0, 5'd4, 5'd7, 5'd0);
    cycle(1'b1);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(C_ADD, 32'h300 + 32'(i), 32'h1, 32'h2, 32'h3, 6'h20, 5'd1, 5'd2, 5'd3);
      cycle(1'b1);
      chk("t6_hold_pc4", 64'(ex_pc4_o), 64'h200);
    end
    stall_i = 1'b0;
    cycle(1'b1);
    chk("t6_release_pc4", 64'(ex_pc4_o), 64'h302);

    // Stall during load-use, then reset mid-stall
    set_id(C_LW, 32'h400, 32'h0, 32'h0, 32'h0, 6'h0, 5'd1, 5'd9, 5'd0);
    cycle(1'b1);
    set_id(C_ADD, 32'h404, 32'h0, 32'h0, 32'h0, 6'h20, 5'd9, 5'd1, 5'd2);
    stall_i = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    stall_i = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    set_id(C_LW, 32'h408, 32'h0, 32'h0, 32'h0, 6'h0, 5'd1, 5'd9, 5'd0);
    cycle(1'b1);
    set_id(C_ADD, 32'h40C, 32'h0, 32'h0, 32'h0, 6'h20, 5'd9, 5'd1, 5'd2);
    stall_i = 1'b1;
    cycle(1'b1);
    rst_i = 1'b1;
    cycle(1'b1);
    rst_i = 1'b0;
    cycle(1'b1);
    stall_i = 1'b0;
    cycle(1'b1);

    // Random mix with small register numbers to provoke hazards
    for (int i = 0; i < 60; i++) begin
      set_id(($urandom_range(0, 1) != 0) ? C_LW : 14'($urandom), $urandom, $urandom, $urandom,
             $urandom, 6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom));
      rst_i   = ($urandom_range(0, 19) == 0);
      flush_i = ($urandom_range(0, 5) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      cycle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
